// File: rtl/lifo_stack.sv
// lifo_stack: operand stack for the postfix calculator datapath.
// Storage is an array of per-entry cells plus an entry counter; the top entry
// is muxed combinationally onto POP_DAT from registered state only.

// One storage word; loads D when WE is high, cleared by reset.
module lifo_cell #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Word register with async clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     Q <= '0;
    else if (WE) Q <= D;
  end

endmodule

module lifo_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH_STB,
  input  logic [WIDTH-1:0] PUSH_DAT,
  input  logic             POP_STB,
  output logic [WIDTH-1:0] POP_DAT
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]                count_q;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [DEPTH-1:0]             we;
  logic                         empty, full;
  logic                         do_push, do_pop, do_repl;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Operation decode: replace the top when both strobes hit a non-empty stack;
  // both strobes on an empty stack degrade to a plain push.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    if (PUSH_STB && POP_STB) begin
      if (empty) do_push = 1'b1;
      else       do_repl = 1'b1;
    end else if (PUSH_STB) begin
      do_push = !full;
    end else if (POP_STB) begin
      do_pop = !empty;
    end
  end

  // Per-entry write enables: push lands at mem[count], replace at mem[count-1]
  always_comb begin
    we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we[i] = (do_push && (count_q == CW'(i))) ||
              (do_repl && (count_q == CW'(i + 1)));
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_cell
      lifo_cell #(.WIDTH(WIDTH)) u_cell (
        .CLK (CLK),
        .RST (RST),
        .WE  (we[g]),
        .D   (PUSH_DAT),
        .Q   (mem[g])
      );
    end
  endgenerate

  // Entry counter; replace leaves it unchanged
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          count_q <= '0;
    else if (do_push) count_q <= count_q + 1'b1;
    else if (do_pop)  count_q <= count_q - 1'b1;
  end

  // Top-of-stack peek; zero when empty, no path from the strobes
  always_comb begin
    POP_DAT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) POP_DAT = mem[i];
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             PUSH_STB = 1'b0;
  logic [WIDTH-1:0] PUSH_DAT = '0;
  logic             POP_STB = 1'b0;
  logic [WIDTH-1:0] POP_DAT;

  int checks = 0;
  int errors = 0;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PUSH_STB (PUSH_STB),
    .PUSH_DAT (PUSH_DAT),
    .POP_STB  (POP_STB),
    .POP_DAT  (POP_DAT)
  );

  always #5 CLK = ~CLK;

  // Reference: a plain queue, back of queue is the top.
  logic [WIDTH-1:0] mq[$];

  function automatic logic [WIDTH-1:0] model_top();
    if (mq.size() == 0) return '0;
    return mq[mq.size() - 1];
  endfunction

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        mq.delete();
      end else if (PUSH_STB && POP_STB) begin
        if (mq.size() == 0) mq.push_back(PUSH_DAT);
        else mq[mq.size() - 1] = PUSH_DAT;
      end else if (PUSH_STB) begin
        if (mq.size() < DEPTH) mq.push_back(PUSH_DAT);
      end else if (POP_STB) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge CLK);
      checks++;
      if (POP_DAT !== model_top()) begin
        errors++;
        $display("FAIL model_cmp t=%0t got %0d expected %0d", $time, POP_DAT, model_top());
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] exp);
    checks++;
    if (POP_DAT !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, POP_DAT, exp);
    end
  endtask

  // Apply strobes for one edge; returns 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [WIDTH-1:0] d, input logic o);
    PUSH_STB = p;
    PUSH_DAT = d;
    POP_STB  = o;
    @(posedge CLK);
    #1;
    PUSH_STB = 1'b0;
    POP_STB  = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d); cyc(1'b1, d, 1'b0); endtask
  task automatic pop();                            cyc(1'b0, '0, 1'b1); endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1 chk("reset_immediate", 0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    // Power-on reset
    @(posedge CLK); #1;
    chk("reset_state", 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Reset and empty peek
    do_reset();
    pop();        chk("pop_empty", 0);
    push(5);      chk("push5", 5);
    pop();        chk("pop5", 0);

    // LIFO order
    push(3); chk("push3", 3);
    push(4); chk("push4", 4);
    push(9); chk("push9", 9);
    pop(); chk("lifo_pop1", 4);
    pop(); chk("lifo_pop2", 3);
    pop(); chk("lifo_pop3", 0);

    // Calculator sequence: peek then pop in the same cycle
    push(2); push(3);
    chk("peek3", 3); pop();
    chk("peek2", 2); pop();
    push(6); chk("push6", 6);
    pop();   chk("calc_empty", 0);

    // Full boundary
    for (int i = 1; i <= DEPTH; i++) push(i);
    chk("full_top", 20);
    push(99); chk("full_ignored", 20);
    // Replace is legal while full
    cyc(1'b1, 77, 1'b1); chk("full_replace", 77);
    cyc(1'b1, 20, 1'b1); chk("full_restore", 20);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      pop();
      chk("drain", i);
    end

    // Simultaneous strobes
    push(7); push(8);
    cyc(1'b1, 5, 1'b1); chk("replace_top", 5);
    pop();              chk("replace_below", 7);
    pop();              chk("replace_empty", 0);
    cyc(1'b1, 11, 1'b1); chk("both_on_empty", 11);
    pop();               chk("both_on_empty_count1", 0);

    // Reset mid-operation with a push pending
    push(1); push(2); push(3);
    PUSH_STB = 1'b1; PUSH_DAT = 42;
    #2 RST = 1'b1;
    #1 chk("reset_mid_op", 0);
    @(posedge CLK); #1;
    PUSH_STB = 1'b0;
    RST = 1'b0;
    chk("after_reset_release", 0);
    push(4); chk("push4_after_reset", 4);
    pop();   chk("pop_after_reset", 0);

    // Randomised traffic, biased to reach both full and empty
    for (int n = 0; n < 3000; n++) begin
      int r, bias;
      bias = ((n / 300) % 2 == 0) ? 65 : 35;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if (r < 10) begin
        cyc(1'b1, $urandom, 1'b1);
      end else if (r < 10 + bias * 85 / 100) begin
        cyc(1'b1, $urandom, 1'b0);
      end else if (r < 95) begin
        cyc(1'b0, $urandom, 1'b1);
      end else begin
        cyc(1'b0, $urandom, 1'b0);
      end
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
